// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source (vsync/hsync/de) with pixel/line coordinates.
// Optional macro VTG_FRAME_CNT_EN adds a 16-bit completed-frame counter on frame_cnt.
`ifndef W_PW
`define W_PW 11
`endif
`ifndef W_PH
`define W_PH 10
`endif

module video_timing_gen #(
    parameter int HSYNC_W = 2,
    parameter int HBP     = 3,
    parameter int HFP     = 1,
    parameter int VSYNC_W = 1,
    parameter int VBP     = 2,
    parameter int VFP     = 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic [`W_PW:0] pic_width,
    input  logic [`W_PH:0] pic_height,
    output logic           vsync,
    output logic           hsync,
    output logic           de,
    output logic [`W_PW:0] x,
    output logic [`W_PH:0] y,
    output logic           sof,
    output logic           eof,
    output logic           busy
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt
`endif
);

    localparam int HC_W = `W_PW + 2;
    localparam int VC_W = `W_PH + 2;
    localparam logic [HC_W-1:0] H_ONE = HC_W'(1);
    localparam logic [VC_W-1:0] V_ONE = VC_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_VSYNC = 3'd1;
    localparam logic [2:0] S_VBP   = 3'd2;
    localparam logic [2:0] S_VACT  = 3'd3;
    localparam logic [2:0] S_VFP   = 3'd4;

    localparam logic [1:0] H_SYNC = 2'd0;
    localparam logic [1:0] H_BP   = 2'd1;
    localparam logic [1:0] H_ACT  = 2'd2;
    localparam logic [1:0] H_FP   = 2'd3;

    logic [2:0]      fs, nxt_fs;
    logic [1:0]      ls, nxt_ls;
    logic [HC_W-1:0] hcnt, nxt_hcnt, h_len;
    logic [VC_W-1:0] vcnt, nxt_vcnt, v_len;
    logic [`W_PW:0]  lat_w, nxt_lat_w;
    logic [`W_PH:0]  lat_h, nxt_lat_h;
    logic            start_ok, h_last, v_last, de_nxt;

    always_comb begin
        h_len = HC_W'(HFP);
        case (ls)
            H_SYNC:  h_len = HC_W'(HSYNC_W);
            H_BP:    h_len = HC_W'(HBP);
            H_ACT:   h_len = {1'b0, lat_w};
            default: h_len = HC_W'(HFP);
        endcase
        v_len = VC_W'(VFP);
        case (fs)
            S_VSYNC: v_len = VC_W'(VSYNC_W);
            S_VBP:   v_len = VC_W'(VBP);
            S_VACT:  v_len = {1'b0, lat_h};
            default: v_len = VC_W'(VFP);
        endcase
    end

    assign start_ok = en && (pic_width != '0) && (pic_height != '0);
    assign h_last   = (hcnt == h_len - H_ONE);
    assign v_last   = (vcnt == v_len - V_ONE);

    // Vertical state advances only on the last clock of a line (end of H_FP).
    always_comb begin
        nxt_fs    = fs;
        nxt_ls    = ls;
        nxt_hcnt  = hcnt;
        nxt_vcnt  = vcnt;
        nxt_lat_w = lat_w;
        nxt_lat_h = lat_h;
        if (fs == S_IDLE) begin
            nxt_ls   = H_SYNC;
            nxt_hcnt = '0;
            nxt_vcnt = '0;
            if (start_ok) begin
                nxt_fs    = S_VSYNC;
                nxt_lat_w = pic_width;
                nxt_lat_h = pic_height;
            end
        end else if (h_last) begin
            nxt_hcnt = '0;
            case (ls)
                H_SYNC:  nxt_ls = H_BP;
                H_BP:    nxt_ls = H_ACT;
                H_ACT:   nxt_ls = H_FP;
                default: nxt_ls = H_SYNC;
            endcase
            if (ls == H_FP) begin
                if (v_last) begin
                    nxt_vcnt = '0;
                    case (fs)
                        S_VSYNC: nxt_fs = S_VBP;
                        S_VBP:   nxt_fs = S_VACT;
                        S_VACT:  nxt_fs = S_VFP;
                        default: begin
                            if (start_ok) begin
                                nxt_fs    = S_VSYNC;
                                nxt_lat_w = pic_width;
                                nxt_lat_h = pic_height;
                            end else begin
                                nxt_fs = S_IDLE;
                            end
                        end
                    endcase
                end else begin
                    nxt_vcnt = vcnt + V_ONE;
                end
            end
        end else begin
            nxt_hcnt = hcnt + H_ONE;
        end
    end

    assign de_nxt = (nxt_fs == S_VACT) && (nxt_ls == H_ACT);

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fs    <= S_IDLE;
            ls    <= H_SYNC;
            hcnt  <= '0;
            vcnt  <= '0;
            lat_w <= '0;
            lat_h <= '0;
            vsync <= 1'b0;
            hsync <= 1'b0;
            de    <= 1'b0;
            x     <= '0;
            y     <= '0;
            sof   <= 1'b0;
            eof   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            fs    <= nxt_fs;
            ls    <= nxt_ls;
            hcnt  <= nxt_hcnt;
            vcnt  <= nxt_vcnt;
            lat_w <= nxt_lat_w;
            lat_h <= nxt_lat_h;
            vsync <= (nxt_fs == S_VSYNC);
            hsync <= (nxt_fs != S_IDLE) && (nxt_ls == H_SYNC);
            de    <= de_nxt;
            x     <= ((nxt_fs != S_IDLE) && (nxt_ls == H_ACT)) ? nxt_hcnt[`W_PW:0] : '0;
            y     <= (nxt_fs == S_VACT) ? nxt_vcnt[`W_PH:0] : '0;
            sof   <= de_nxt && (nxt_hcnt == '0) && (nxt_vcnt == '0);
            eof   <= de_nxt && (nxt_hcnt == {1'b0, nxt_lat_w} - H_ONE)
                            && (nxt_vcnt == {1'b0, nxt_lat_h} - V_ONE);
            busy  <= (nxt_fs != S_IDLE);
        end
    end

`ifdef VTG_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= 16'd0;
        end else if (eof) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
